branch_fetch: RTL and testbench
===============================

# branch_fetch

Fetch-side partner of the EX-stage branch resolver. Owns the PC register and selects the next fetch address from a flush redirect, stall, a BTB prediction gated by a 2-bit branch history table (BHT), or sequential PC+1. Carries each instruction's predicted-taken bit through IF/ID and ID/EX so the resolver can compare it against the actual outcome. Keeps branch and mispredict counters and sits between the PC mux and the IF/ID register.

## Interface

Parameters:
- BHT_INDEX_BITS, 4: log2 of the BHT entry count. The index is pc[BHT_INDEX_BITS-1:0].
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; every register updates on the rising edge
- reset  in  1  synchronous, active-high
- stall  in  `NUM_PIPE_MASKS  per-register hold mask (`PIPE_REG_PC, `PIPE_REG_IF_ID, `PIPE_REG_ID_EX)
- flush  in  `NUM_PIPE_MASKS  flush mask from the branch resolver
- jump_address  in  `ADDR_WIDTH  redirect target; valid when flush has the `PIPE_REG_PC bit set
- take_branch  in  1  BTB hit for the current pc
- branch_predict  in  `ADDR_WIDTH  BTB target for the current pc
- resolve_valid  in  1  one-cycle pulse, one per resolved conditional branch in EX
- resolve_taken  in  1  actual outcome, qualified by resolve_valid
- id_ex_pc  in  `ADDR_WIDTH  PC of the resolving branch; used as the BHT update index
- pc  out  `ADDR_WIDTH  current fetch address
- if_id_pc  out  `ADDR_WIDTH  PC held in IF/ID
- if_id_branch_taken  out  1  prediction bit held in IF/ID
- branch_taken  out  1  prediction bit held in ID/EX; feeds the resolver
- branch_count  out  32  resolved conditional branches
- mispredict_count  out  32  PC redirects caused by flush

## Operation

- pred_taken = take_branch AND the BHT counter at pc has value ≥ 2'b10. This signal is combinational.
- Next pc, in priority order:
  - reset → RESET_PC
  - flush & `PIPE_REG_PC → jump_address
  - stall & `PIPE_REG_PC → hold
  - pred_taken → branch_predict
  - otherwise → pc+1, wrapping modulo 2^`ADDR_WIDTH
- IF/ID register (if_id_pc, if_id_branch_taken), in priority order:
  - reset or flush & `PIPE_REG_IF_ID → 0
  - stall & `PIPE_REG_IF_ID → hold
  - otherwise → load pc and pred_taken
- ID/EX bit (branch_taken): same rule using `PIPE_REG_ID_EX, loaded from if_id_branch_taken.
- Flush always beats stall on the same register.
- BHT:
  - 2^BHT_INDEX_BITS two-bit saturating counters; reset sets all of them to 2'b01 (weakly not-taken).
  - On resolve_valid, the entry at id_ex_pc[BHT_INDEX_BITS-1:0] increments if resolve_taken, otherwise decrements.
  - Counters saturate at 2'b11 and 2'b00.
  - Updates are not gated by stall.
  - Aliasing PCs share an entry.
- Counters:
  - branch_count increments on resolve_valid.
  - mispredict_count increments when flush & `PIPE_REG_PC and not reset.
  - Both wrap at 2^32.
- An unconditional jump flush that omits the PC bit (EX/MEM only) does not redirect and does not count.

## Timing

- Reset values:
  - pc = RESET_PC
  - if_id_pc = 0, if_id_branch_taken = 0, branch_taken = 0
  - both counters = 0
  - every BHT entry = 2'b01
- Reset asserted mid-operation overrides flush, stall and BHT writes in that cycle.
- Redirect latency: a flush in cycle N gives pc = jump_address in cycle N+1. IF/ID and ID/EX read 0 in N+1.
- Prediction latency: a BTB hit plus a taken counter in cycle N gives pc = branch_predict in N+1. The bit reaches IF/ID in N+1 and branch_taken in N+2, absent stalls.
- BHT read and write to the same index in one cycle: the read returns the old value and the new value is visible in the next cycle.
- A stall on PC only, without IF/ID, still loads IF/ID each cycle. Bubble insertion is the hazard unit's responsibility.

## Structure

- `ADDR_WIDTH, `NUM_PIPE_MASKS and the `PIPE_REG_* mask bits come from the shared defines header. No new constants go into it except a BHT reset constant, `BHT_WEAK_NT = 2'b01.
- One sub-module, branch_history_table: counter array with a combinational read port, a registered saturating update port, and synchronous reset.
- The top level holds the PC mux, the pipeline prediction registers and the performance counters.

## Test plan

- Reset, then free run with no stall, flush or hit → pc 0,1,2,3 on consecutive cycles; all outputs at reset values during reset.
- take_branch=1, branch_predict=0x20 at pc=0x05 with a fresh BHT → pc goes to 0x06. Then two resolve_valid/resolve_taken pulses with id_ex_pc=0x05, and pc returns to 0x05 → pc goes to 0x20; if_id_branch_taken=1 next cycle and branch_taken=1 the cycle after.
- flush = PC|IF_ID|ID_EX|EX_MEM with jump_address=0x40 → pc=0x40 next cycle, both prediction bits 0, mispredict_count+1. A flush of EX_MEM only → no change.
- stall=PC|IF_ID for 3 cycles → pc and if_id_pc hold. Flush with the PC bit and stall on the same cycle → the redirect wins.
- Saturation and aliasing with BHT_INDEX_BITS=4: five taken resolves at id_ex_pc=0x03 leave the counter at 11. One not-taken leaves 10, still predicting taken. A BTB hit at pc=0x13 predicts taken through the shared entry.
- Reset asserted on the same cycle as a flush and a resolve_valid → pc=RESET_PC, BHT back to 01, both counters 0.

Source files
------------

// File: rtl/branch_fetch_pkg.sv
// rtl/branch_fetch_pkg.sv - shared defines, types and BHT counter helpers for branch_fetch
`ifndef BRANCH_FETCH_DEFINES
`define BRANCH_FETCH_DEFINES
`define ADDR_WIDTH      32
`define NUM_PIPE_MASKS  5
`define PIPE_REG_PC     5'b00001
`define PIPE_REG_IF_ID  5'b00010
`define PIPE_REG_ID_EX  5'b00100
`define PIPE_REG_EX_MEM 5'b01000
`define PIPE_REG_MEM_WB 5'b10000
`define BHT_WEAK_NT     2'b01
`endif

package branch_fetch_pkg;

  typedef logic [`ADDR_WIDTH-1:0]     addr_t;
  typedef logic [`NUM_PIPE_MASKS-1:0] pipe_mask_t;
  typedef logic [1:0]                 bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = `BHT_WEAK_NT;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

  function automatic logic bht_taken(input bht_ctr_t ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/branch_fetch_if.sv
// rtl/branch_fetch_if.sv - fetch-side control and status bundle for branch_fetch
interface branch_fetch_if;
  import branch_fetch_pkg::*;

  pipe_mask_t  stall;
  pipe_mask_t  flush;
  addr_t       jump_address;
  logic        take_branch;
  addr_t       branch_predict;
  logic        resolve_valid;
  logic        resolve_taken;
  addr_t       id_ex_pc;
  addr_t       pc;
  addr_t       if_id_pc;
  logic        if_id_branch_taken;
  logic        branch_taken;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport slave (
    input  stall, flush, jump_address, take_branch, branch_predict,
    input  resolve_valid, resolve_taken, id_ex_pc,
    output pc, if_id_pc, if_id_branch_taken, branch_taken,
    output branch_count, mispredict_count
  );

  modport master (
    output stall, flush, jump_address, take_branch, branch_predict,
    output resolve_valid, resolve_taken, id_ex_pc,
    input  pc, if_id_pc, if_id_branch_taken, branch_taken,
    input  branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_fetch_bht.sv
// rtl/branch_fetch_bht.sv - 2-bit saturating branch history table, async read, registered update
module branch_history_table
  import branch_fetch_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output bht_ctr_t              rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic                  wr_taken
);

  localparam int ENTRIES = 2 ** INDEX_BITS;

  bht_ctr_t ctr_q [ENTRIES];
  bht_ctr_t ctr_d [ENTRIES];

  // Read sees the pre-update value; a same-index write lands next cycle.
  assign rd_ctr = ctr_q[rd_index];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      ctr_d[wr_index] = bht_next(ctr_q[wr_index], wr_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BHT_RESET;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_fetch.sv
// rtl/branch_fetch.sv - PC mux with BHT-gated BTB prediction, IF/ID and ID/EX prediction bits, perf counters
module branch_fetch
  import branch_fetch_pkg::*;
#(
  parameter int    BHT_INDEX_BITS = 4,
  parameter addr_t RESET_PC       = '0
) (
  input  logic           clk,
  input  logic           reset,
  branch_fetch_if.slave  bus
);

  addr_t       pc_q, pc_d;
  addr_t       if_id_pc_q, if_id_pc_d;
  logic        if_id_bt_q, if_id_bt_d;
  logic        branch_taken_q, branch_taken_d;
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  bht_ctr_t bht_ctr;
  logic     pred_taken;
  logic     flush_pc, flush_if_id, flush_id_ex;
  logic     stall_pc, stall_if_id, stall_id_ex;

  assign flush_pc    = |(bus.flush & `PIPE_REG_PC);
  assign flush_if_id = |(bus.flush & `PIPE_REG_IF_ID);
  assign flush_id_ex = |(bus.flush & `PIPE_REG_ID_EX);
  assign stall_pc    = |(bus.stall & `PIPE_REG_PC);
  assign stall_if_id = |(bus.stall & `PIPE_REG_IF_ID);
  assign stall_id_ex = |(bus.stall & `PIPE_REG_ID_EX);

  branch_history_table #(
    .INDEX_BITS (BHT_INDEX_BITS)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_index (pc_q[BHT_INDEX_BITS-1:0]),
    .rd_ctr   (bht_ctr),
    .wr_en    (bus.resolve_valid),
    .wr_index (bus.id_ex_pc[BHT_INDEX_BITS-1:0]),
    .wr_taken (bus.resolve_taken)
  );

  assign pred_taken = bus.take_branch & bht_taken(bht_ctr);

  always_comb begin
    pc_d               = pc_q + addr_t'(1);
    if_id_pc_d         = pc_q;
    if_id_bt_d         = pred_taken;
    branch_taken_d     = if_id_bt_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    // Redirect beats stall beats prediction.
    if (flush_pc) begin
      pc_d = bus.jump_address;
    end else if (stall_pc) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = bus.branch_predict;
    end

    if (flush_if_id) begin
      if_id_pc_d = '0;
      if_id_bt_d = 1'b0;
    end else if (stall_if_id) begin
      if_id_pc_d = if_id_pc_q;
      if_id_bt_d = if_id_bt_q;
    end

    if (flush_id_ex) begin
      branch_taken_d = 1'b0;
    end else if (stall_id_ex) begin
      branch_taken_d = branch_taken_q;
    end

    if (bus.resolve_valid) begin
      branch_count_d = branch_count_q + 32'd1;
    end
    if (flush_pc) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q               <= RESET_PC;
      if_id_pc_q         <= '0;
      if_id_bt_q         <= 1'b0;
      branch_taken_q     <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      pc_q               <= pc_d;
      if_id_pc_q         <= if_id_pc_d;
      if_id_bt_q         <= if_id_bt_d;
      branch_taken_q     <= branch_taken_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.pc                 = pc_q;
  assign bus.if_id_pc           = if_id_pc_q;
  assign bus.if_id_branch_taken = if_id_bt_q;
  assign bus.branch_taken       = branch_taken_q;
  assign bus.branch_count       = branch_count_q;
  assign bus.mispredict_count   = mispredict_count_q;

endmodule

// File: tb/tb_branch_fetch.sv
// tb/tb_branch_fetch.sv - per-cycle vector table with expected-output scoreboard for branch_fetch
module tb_branch_fetch;
  import branch_fetch_pkg::*;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] F_PC   = 5'b00001;
  localparam logic [4:0] F_IF   = 5'b00010;
  localparam logic [4:0] F_ID   = 5'b00100;
  localparam logic [4:0] F_EX   = 5'b01000;

  typedef struct {
    logic        rst;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic [31:0] jump;
    logic        tb;
    logic [31:0] bp;
    logic        rv;
    logic        rt;
    logic [31:0] ixp;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic        ifbt;
    logic        bt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  stim_t stims[$];
  exp_t  exps[$];
  exp_t  sb_q[$];

  branch_fetch_if bus ();

  branch_fetch #(
    .BHT_INDEX_BITS (4),
    .RESET_PC       (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic [4:0] stall, input logic [4:0] flush,
                     input logic [31:0] jump, input logic tb, input logic [31:0] bp,
                     input logic rv, input logic rt, input logic [31:0] ixp,
                     input logic [31:0] e_pc, input logic [31:0] e_ifpc, input logic e_ifbt,
                     input logic e_bt, input logic [31:0] e_bc, input logic [31:0] e_mc);
    stim_t s;
    exp_t  e;
    s = '{rst, stall, flush, jump, tb, bp, rv, rt, ixp};
    e = '{e_pc, e_ifpc, e_ifbt, e_bt, e_bc, e_mc};
    stims.push_back(s);
    exps.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    bus.stall = '0; bus.flush = '0; bus.jump_address = '0;
    bus.take_branch = 1'b0; bus.branch_predict = '0;
    bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0; bus.id_ex_pc = '0;

    //  rst stall   flush  jump         tb bp        rv rt ixp     pc           ifpc         ifbt bt bc mc
    add(1, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h00,      32'h00,      0, 0, 0, 0);
    add(1, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h00,      32'h00,      0, 0, 0, 0);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h01,      32'h00,      0, 0, 0, 0);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h02,      32'h01,      0, 0, 0, 0);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h03,      32'h02,      0, 0, 0, 0);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h04,      32'h03,      0, 0, 0, 0);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h05,      32'h04,      0, 0, 0, 0);
    // BTB hit at 0x05 with a weakly-not-taken counter falls through
    add(0, S_NONE, S_NONE, 0,           1, 32'h20,   0, 0, 0,      32'h06,      32'h05,      0, 0, 0, 0);
    add(0, S_NONE, S_NONE, 0,           0, 0,        1, 1, 32'h05, 32'h07,      32'h06,      0, 0, 1, 0);
    add(0, S_NONE, S_NONE, 0,           0, 0,        1, 1, 32'h05, 32'h08,      32'h07,      0, 0, 2, 0);
    add(0, S_NONE, F_PC|F_IF|F_ID, 32'h05, 0, 0,    0, 0, 0,      32'h05,      32'h00,      0, 0, 2, 1);
    add(0, S_NONE, S_NONE, 0,           1, 32'h20,   0, 0, 0,      32'h20,      32'h05,      1, 0, 2, 1);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h21,      32'h20,      0, 1, 2, 1);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h22,      32'h21,      0, 0, 2, 1);
    add(0, S_NONE, F_PC|F_IF|F_ID|F_EX, 32'h40, 0, 0, 0, 0, 0,    32'h40,      32'h00,      0, 0, 2, 2);
    add(0, S_NONE, F_EX,   32'h99,      0, 0,        0, 0, 0,      32'h41,      32'h40,      0, 0, 2, 2);
    // stall PC|IF_ID holds both, then a PC flush under stall still redirects
    add(0, F_PC|F_IF, S_NONE, 0,        0, 0,        0, 0, 0,      32'h41,      32'h40,      0, 0, 2, 2);
    add(0, F_PC|F_IF, S_NONE, 0,        0, 0,        0, 0, 0,      32'h41,      32'h40,      0, 0, 2, 2);
    add(0, F_PC|F_IF, S_NONE, 0,        0, 0,        0, 0, 0,      32'h41,      32'h40,      0, 0, 2, 2);
    add(0, F_PC|F_IF, F_PC, 32'h50,     0, 0,        0, 0, 0,      32'h50,      32'h40,      0, 0, 2, 3);
    add(0, F_PC,   S_NONE, 0,           0, 0,        0, 0, 0,      32'h50,      32'h50,      0, 0, 2, 3);
    add(0, F_PC,   S_NONE, 0,           0, 0,        0, 0, 0,      32'h50,      32'h50,      0, 0, 2, 3);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h51,      32'h50,      0, 0, 2, 3);
    // five taken resolves saturate entry 3, one not-taken leaves it at 10
    add(0, S_NONE, S_NONE, 0,           0, 0,        1, 1, 32'h03, 32'h52,      32'h51,      0, 0, 3, 3);
    add(0, S_NONE, S_NONE, 0,           0, 0,        1, 1, 32'h03, 32'h53,      32'h52,      0, 0, 4, 3);
    add(0, S_NONE, S_NONE, 0,           0, 0,        1, 1, 32'h03, 32'h54,      32'h53,      0, 0, 5, 3);
    add(0, S_NONE, S_NONE, 0,           0, 0,        1, 1, 32'h03, 32'h55,      32'h54,      0, 0, 6, 3);
    add(0, S_NONE, S_NONE, 0,           0, 0,        1, 1, 32'h03, 32'h56,      32'h55,      0, 0, 7, 3);
    add(0, S_NONE, S_NONE, 0,           0, 0,        1, 0, 32'h03, 32'h57,      32'h56,      0, 0, 8, 3);
    add(0, S_NONE, F_PC,   32'h13,      0, 0,        0, 0, 0,      32'h13,      32'h57,      0, 0, 8, 4);
    add(0, S_NONE, S_NONE, 0,           1, 32'h70,   0, 0, 0,      32'h70,      32'h13,      1, 0, 8, 4);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h71,      32'h70,      0, 1, 8, 4);
    // same-index read/write: old counter used now, new one next time
    add(0, S_NONE, S_NONE, 0,           1, 32'h30,   1, 1, 32'h01, 32'h72,      32'h71,      0, 0, 9, 4);
    add(0, S_NONE, F_PC,   32'h71,      0, 0,        0, 0, 0,      32'h71,      32'h72,      0, 0, 9, 5);
    add(0, S_NONE, S_NONE, 0,           1, 32'h30,   0, 0, 0,      32'h30,      32'h71,      1, 0, 9, 5);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h31,      32'h30,      0, 1, 9, 5);
    // reset beats a simultaneous flush and resolve; BHT[5] back to weak NT
    add(1, S_NONE, F_PC|F_IF|F_ID|F_EX, 32'h88, 0, 0, 1, 1, 32'h05, 32'h00,  32'h00,      0, 0, 0, 0);
    add(0, S_NONE, F_PC,   32'h05,      0, 0,        0, 0, 0,      32'h05,      32'h00,      0, 0, 0, 1);
    add(0, S_NONE, S_NONE, 0,           1, 32'h20,   0, 0, 0,      32'h06,      32'h05,      0, 0, 0, 1);
    add(0, S_NONE, F_PC,   32'hFFFF_FFFF, 0, 0,      0, 0, 0,      32'hFFFF_FFFF, 32'h06,    0, 0, 0, 2);
    add(0, S_NONE, S_NONE, 0,           0, 0,        0, 0, 0,      32'h00,      32'hFFFF_FFFF, 0, 0, 0, 2);

    for (int i = 0; i < stims.size(); i++) begin
      @(negedge clk);
      reset              = stims[i].rst;
      bus.stall          = stims[i].stall;
      bus.flush          = stims[i].flush;
      bus.jump_address   = stims[i].jump;
      bus.take_branch    = stims[i].tb;
      bus.branch_predict = stims[i].bp;
      bus.resolve_valid  = stims[i].rv;
      bus.resolve_taken  = stims[i].rt;
      bus.id_ex_pc       = stims[i].ixp;
      sb_q.push_back(exps[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("pc",                 i, bus.pc,                         e.pc);
      check("if_id_pc",           i, bus.if_id_pc,                   e.ifpc);
      check("if_id_branch_taken", i, {31'b0, bus.if_id_branch_taken}, {31'b0, e.ifbt});
      check("branch_taken",       i, {31'b0, bus.branch_taken},       {31'b0, e.bt});
      check("branch_count",       i, bus.branch_count,               e.bc);
      check("mispredict_count",   i, bus.mispredict_count,           e.mc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
